// File: rtl/uart_tx.sv
// Byte-wide UART transmitter, 8N1 by default; define UART_TX_PARITY_EN to add
// an even parity bit between the data bits and the stop bit (8E1).
module uart_tx #(
  parameter int unsigned CLK_HZ  = 27_000_000,
  parameter int unsigned BAUD    = 115200,
  parameter int unsigned DIVISOR = (CLK_HZ + BAUD / 2) / BAUD
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int unsigned CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIVISOR - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             baud_wrap;
`ifdef UART_TX_PARITY_EN
  logic             parity;
`endif

  assign baud_wrap = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_o     <= 1'b1;
      busy_o   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      if (state != S_IDLE) begin
        baud_cnt <= baud_wrap ? '0 : baud_cnt + CNT_W'(1);
      end
      case (state)
        S_IDLE: begin
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
          if (start_i) begin
            shift    <= data_i;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_o     <= 1'b0;
            busy_o   <= 1'b1;
            state    <= S_START;
`ifdef UART_TX_PARITY_EN
            parity   <= ^data_i;
`endif
          end
        end
        S_START: begin
          if (baud_wrap) begin
            tx_o  <= shift[0];
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_wrap) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_o  <= parity;
              state <= S_PARITY;
`else
              tx_o  <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              // Present the next bit on the same edge the register shifts.
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx_o    <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_wrap) begin
            tx_o  <= 1'b1;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (baud_wrap) begin
            tx_o   <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIVISOR = 4; follows UART_TX_PARITY_EN if defined.
module tb_uart_tx;

  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk;
  logic       rstn_i;
  logic       start_i;
  logic [7:0] data_i;
  logic       tx_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  uart_tx #(
    .CLK_HZ(1_000_000),
    .BAUD  (250_000)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn_i),
    .start_i(start_i),
    .data_i (data_i),
    .tx_o   (tx_o),
    .busy_o (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a start bit, then samples each bit in its middle.
  task automatic capture_frame(output logic [7:0] b, output logic p,
                               output logic stp, output bit found);
    found = 0;
    b = 'x; p = 1'bx; stp = 1'bx;
    for (int i = 0; i < 200; i++) begin
      if (tx_o === 1'b0) begin
        found = 1;
        break;
      end
      tick();
    end
    if (found) begin
      repeat (D / 2) tick();
      for (int k = 0; k < 8; k++) begin
        repeat (D) tick();
        b[k] = tx_o;
      end
`ifdef UART_TX_PARITY_EN
      repeat (D) tick();
      p = tx_o;
`endif
      repeat (D) tick();
      stp = tx_o;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < FB * D + 8) begin
      tick();
      n++;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy_o got %b required 0 within %0d cycles", name, busy_o, FB * D + 8);
    end
  endtask

  task automatic test_reset;
    rstn_i = 1'b0;
    start_i = 1'b0;
    data_i = 8'h00;
    repeat (3) tick();
    checks++;
    if ({tx_o, busy_o} !== 2'b10) begin
      errors++;
      $display("FAIL reset_hold: tx/busy got %b required 10", {tx_o, busy_o});
    end
    rstn_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({tx_o, busy_o} !== 2'b10) begin
        errors++;
        $display("FAIL reset_idle[%0d]: tx/busy got %b required 10", i, {tx_o, busy_o});
      end
    end
  endtask

  task automatic test_single_frame;
    logic [10:0] seq;
    int busy_cnt;
`ifdef UART_TX_PARITY_EN
    seq = 11'h4AA;
`else
    seq = 11'h2AA;
`endif
    data_i = 8'h55;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < FB * D; i++) begin
      checks++;
      if (tx_o !== seq[i / D]) begin
        errors++;
        $display("FAIL single_tx[%0d]: tx_o got %b required %b", i, tx_o, seq[i / D]);
      end
      if (busy_o === 1'b1) busy_cnt++;
      tick();
    end
    checks++;
    if ({tx_o, busy_o} !== 2'b10) begin
      errors++;
      $display("FAIL single_end: tx/busy got %b required 10", {tx_o, busy_o});
    end
    repeat (4) begin
      if (busy_o === 1'b1) busy_cnt++;
      tick();
    end
    checks++;
    if (busy_cnt != FB * D) begin
      errors++;
      $display("FAIL single_busy_len: got %0d required %0d", busy_cnt, FB * D);
    end
  endtask

  task automatic test_handshake;
    int n;
    int bad;
    logic [7:0] b;
    logic p, stp;
    bit found;
    data_i = 8'hA3;
    start_i = 1'b1;
    n = 0;
    while (busy_o !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    start_i = 1'b0;
    data_i = 8'hFF;
    checks++;
    if (busy_o !== 1'b1 || n != 1) begin
      errors++;
      $display("FAIL hs_busy_latency: busy_o %b after %0d cycles, required 1 after 1", busy_o, n);
    end
    capture_frame(b, p, stp, found);
    checks++;
    if (!found || b !== 8'hA3) begin
      errors++;
      $display("FAIL hs_data: got %h (found %0d) required a3", b, found);
    end
    checks++;
    if (stp !== 1'b1) begin
      errors++;
      $display("FAIL hs_stop: got %b required 1", stp);
    end
`ifdef UART_TX_PARITY_EN
    checks++;
    if (p !== 1'b0) begin
      errors++;
      $display("FAIL hs_parity: got %b required 0", p);
    end
`endif
    wait_idle("hs_idle");
    bad = 0;
    for (int i = 0; i < 3 * FB * D; i++) begin
      tick();
      if ({tx_o, busy_o} !== 2'b10) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hs_no_second_frame: %0d active cycles, required 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int p;
    logic exp_tx, exp_busy;
    data_i = 8'h00;
    start_i = 1'b1;
    n = 0;
    while (busy_o !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start: busy_o got %b required 1", busy_o);
    end
    for (int i = 0; i < 3 * (FB * D + 1); i++) begin
      p = i % (FB * D + 1);
      exp_tx = (p >= (FB - 1) * D);
      exp_busy = (p < FB * D);
      checks++;
      if (tx_o !== exp_tx || busy_o !== exp_busy) begin
        errors++;
        $display("FAIL b2b[%0d]: tx/busy got %b%b required %b%b", i, tx_o, busy_o, exp_tx, exp_busy);
      end
      tick();
    end
    start_i = 1'b0;
    wait_idle("b2b_idle");
  endtask

  task automatic test_reset_mid_frame;
    int bad;
    logic [7:0] b;
    logic p, stp;
    bit found;
    data_i = 8'h0F;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (4 * D + 1) tick();
    checks++;
    if ({tx_o, busy_o} !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid_pre: tx/busy got %b required 11", {tx_o, busy_o});
    end
    #2 rstn_i = 1'b0;
    #1;
    checks++;
    if ({tx_o, busy_o} !== 2'b10) begin
      errors++;
      $display("FAIL rst_mid_async: tx/busy got %b required 10", {tx_o, busy_o});
    end
    repeat (2) tick();
    rstn_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 4 * FB * D; i++) begin
      tick();
      if ({tx_o, busy_o} !== 2'b10) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: %0d active cycles, required 0", bad);
    end
    data_i = 8'h3C;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    capture_frame(b, p, stp, found);
    checks++;
    if (!found || b !== 8'h3C || stp !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_restart: got data %h stop %b required 3c stop 1", b, stp);
    end
    wait_idle("rst_mid_idle");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0] vals [2];
    logic       exp_p [2];
    logic       par;
    int         busy_cnt;
    vals[0] = 8'h07; exp_p[0] = 1'b1;
    vals[1] = 8'h03; exp_p[1] = 1'b0;
    for (int v = 0; v < 2; v++) begin
      data_i = vals[v];
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      busy_cnt = 0;
      par = 1'bx;
      for (int i = 0; i < FB * D + 4; i++) begin
        if (i == 9 * D + 2) par = tx_o;
        if (busy_o === 1'b1) busy_cnt++;
        tick();
      end
      checks++;
      if (par !== exp_p[v]) begin
        errors++;
        $display("FAIL parity_bit(%h): got %b required %b", vals[v], par, exp_p[v]);
      end
      checks++;
      if (busy_cnt != 44) begin
        errors++;
        $display("FAIL parity_busy_len(%h): got %0d required 44", vals[v], busy_cnt);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_handshake();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
